clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Parametrised, multi-channel successor to the fixed power-of-two divider.
- Each channel divides `clk` by a runtime-programmable integer divisor and produces two outputs:
  - a divided level `clk_out`, with duty cycle ceil(D/2) high and floor(D/2) low;
  - a one-cycle `tick` strobe per period.
- Divisor changes take effect only at period boundaries, so outputs never glitch or produce runt periods.
- Sits in the clocking/timebase area and feeds clock-enables to downstream counters, UART/PWM blocks and display scanning.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- DIV_W, 8, divisor width; legal divisors 0..2^DIV_W-1.
- DEF_DIV, 2, divisor loaded into every channel at reset (must be >=1 and < 2^DIV_W).
- CH_W, max(1,$clog2(NUM_CH)), channel-select width (derived, not overridden).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 resets on the next posedge).
- en  in  1  global count enable; 0 freezes all counters and outputs.
- sync_clr  in  1  synchronous restart of all channels (phase-align).
- wr_en  in  1  divisor write strobe.
- wr_ch  in  CH_W  channel addressed by the write.
- wr_div  in  DIV_W  new divisor value.
- clk_out  out  NUM_CH  divided level per channel (registered).
- tick  out  NUM_CH  one-cycle strobe in the last cycle of each period (registered).
- pending  out  NUM_CH  1 = a written divisor is waiting for the next boundary.

Behaviour:
- **Per-channel state:** cnt[DIV_W], act_div[DIV_W], pend_div[DIV_W], pend.
  - H = (act_div+1)>>1 is the number of high cycles.
- **Reset (rst==0 at posedge):** act_div=DEF_DIV, cnt=DEF_DIV-1, pend=0, pend_div=0, clk_out=0, tick=0.
  - Reset overrides every other input.
- **Enabled edge (en=1, act_div>=1):**
  - cnt_n = (cnt==act_div-1) ? 0 : cnt+1.
  - clk_out <= (cnt_n < H); tick <= (cnt_n == act_div-1); cnt <= cnt_n.
- **Wrap:** a wrap is an enabled edge where cnt==act_div-1.
  - If pend=1, the wrap loads act_div<=pend_div and clears pend.
  - cnt_n, clk_out and tick for that edge are computed with the new divisor.
- **Write timing:**
  - A write (wr_en=1, wr_ch<NUM_CH) on a non-wrap edge sets pend_div<=wr_div and pend<=1.
  - A write on a wrap edge bypasses pending and is used by that wrap directly; pending stays 0.
  - A second write before the boundary overwrites pend_div (last write wins).
  - wr_ch>=NUM_CH is ignored.
- **D=1:** cnt stays 0; clk_out=1 and tick=1 on every enabled edge.
- **D=0 (stopped channel):** cnt held 0, clk_out<=0, tick<=0.
  - A nonzero write applies on the next edge, without waiting for a boundary: act_div<=wr_div, cnt<=wr_div-1, pend stays 0, outputs low that edge.
  - Counting resumes on the following enabled edge.
- **D=0 written to a running channel:** pends; the channel stops at the next wrap with outputs low.
- **en=0:** cnt, clk_out and tick hold their values, so tick may stay high while frozen and downstream logic must qualify it with en.
  - Writes are still accepted into pending.
  - Pending writes apply at the next wrap after en returns to 1.
- **sync_clr=1 (priority below rst, above en):**
  - All channels: cnt<=act_div'-1, clk_out<=0, tick<=0, pend<=0.
  - act_div' = pend_div if pend, else a same-cycle write's wr_div, else act_div.
  - First enabled edge afterwards starts every channel in phase (clk_out=1).
- **Width rule:** cnt never exceeds act_div-1. Compare with full DIV_W width, with no truncation of act_div-1 when act_div=0 (that case is handled separately).
- **Latency:** output edges align exactly to the posedge that moves cnt; there is no extra pipeline stage.

Decomposition:
- Package clk_div_pkg: DIV_W default, function half_hi(d) = (d+1)>>1, localparam for CH_W derivation.
- Sub-module clk_div_channel: one counter, act/pend registers and output regs per channel.
- Top clk_div_multi decodes the write, generates NUM_CH instances, and fans out en, sync_clr and rst.

Test Plan:
- **Reset/default:** rst=0 for 2 cycles, then en=1 with DEF_DIV=2 → every channel clk_out toggles 1,0,1,0… from the first edge; tick high on each 0 cycle; pending=0.
- **Odd divisor:** write ch1 div=5 at reset-time boundary → steady period 5: clk_out 1,1,1,0,0; tick coincides with the 2nd low cycle; no runt period at the switch.
- **Mid-period change:** ch0 running D=4; write D=3 at cnt=1 → pending[0]=1 for 2 cycles; the current 4-cycle period completes, then 3-cycle periods; a write on the wrap edge itself applies immediately with pending never set.
- **Stop/start:** write D=0 to ch2 → outputs low after the current period; write D=6 → next edge loads, following edge clk_out=1, period 6.
- **D=1 and freeze:** ch3 D=1 → clk_out=1, tick=1 continuously; drop en for 5 cycles → all counters and outputs hold; write ch0 during freeze → applies at the first wrap after en=1.
- **sync_clr alignment:** channels at D=2,3,4,5 with random phases; pulse sync_clr → all outputs 0 for that edge, then all clk_out rise together; ticks realign at cycle 60 (LCM); wr_ch=NUM_CH writes are ignored.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   DIV_W_DEF : default divisor width
//   half_hi   : number of high cycles for a divisor d, ceil(d/2)
//   ch_width  : channel-select width for a given channel count (minimum 1)
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF = 8;

  // High-phase length of a period of d cycles.
  function automatic int unsigned half_hi(input int unsigned d);
    return (d + 32'd1) >> 1;
  endfunction

  // Select width; a single channel still needs a one-bit select port.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: period counter, active/pending divisor registers and
// registered outputs.
//   clk, rst     : clock, synchronous active-low reset
//   en           : count enable (0 freezes counter and outputs)
//   sync_clr     : restart this channel at the top of its period
//   wr, wr_div   : divisor write addressed to this channel
//   clk_out      : divided level, ceil(D/2) high then floor(D/2) low
//   tick         : strobe in the last cycle of each period
//   pending      : a written divisor waits for the next period boundary
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DEF,
  parameter int unsigned DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] act_q, act_d;
  logic [DIV_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] last_c;
  logic [DIV_W-1:0] inc_c;
  logic [DIV_W-1:0] nd_c;
  logic             wrap_c;

  // Next-state logic; priority sync_clr > stopped > frozen > wrap > count.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    clk_d  = clk_q;
    tick_d = tick_q;
    last_c = act_q - DIV_W'(1);
    inc_c  = cnt_q + DIV_W'(1);
    nd_c   = act_q;
    // act_q==0 is excluded so last_c's underflow never matches.
    wrap_c = en && (act_q != '0) && (cnt_q == last_c);

    if (sync_clr) begin
      if (pend_q) begin
        nd_c = pdiv_q;
      end else if (wr) begin
        nd_c = wr_div;
      end
      act_d  = nd_c;
      cnt_d  = (nd_c == '0) ? '0 : nd_c - DIV_W'(1);
      pend_d = 1'b0;
      clk_d  = 1'b0;
      tick_d = 1'b0;
    end else if (act_q == '0) begin
      // Stopped channel: a nonzero write loads at once, parked on the
      // last count so the next enabled edge starts a fresh period.
      cnt_d = '0;
      if (wr && (wr_div != '0)) begin
        act_d = wr_div;
        cnt_d = wr_div - DIV_W'(1);
      end
      if (en) begin
        clk_d  = 1'b0;
        tick_d = 1'b0;
      end
    end else if (!en) begin
      if (wr) begin
        pdiv_d = wr_div;
        pend_d = 1'b1;
      end
    end else if (wrap_c) begin
      // Same-cycle write is newer than any pending value.
      if (wr) begin
        nd_c = wr_div;
      end else if (pend_q) begin
        nd_c = pdiv_q;
      end
      act_d  = nd_c;
      pend_d = 1'b0;
      cnt_d  = '0;
      clk_d  = (nd_c != '0);
      tick_d = (nd_c == DIV_W'(1));
    end else begin
      cnt_d  = inc_c;
      clk_d  = (32'(inc_c) < half_hi(32'(act_q)));
      tick_d = (inc_c == last_c);
      if (wr) begin
        pdiv_d = wr_div;
        pend_d = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= DIV_W'(DEF_DIV - 32'd1);
      act_q  <= DIV_W'(DEF_DIV);
      pdiv_q <= '0;
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable integer clock divider.
//   clk, rst          : clock, synchronous active-low reset
//   en                : global count enable
//   sync_clr          : phase-align restart of all channels
//   wr_en/wr_ch/wr_div: divisor write; out-of-range channels are ignored
//   clk_out, tick     : per-channel divided level and period strobe
//   pending           : per-channel divisor-waiting flag
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter  int unsigned NUM_CH  = 4,
  parameter  int unsigned DIV_W   = DIV_W_DEF,
  parameter  int unsigned DEF_DIV = 2,
  localparam int unsigned CH_W    = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DIV_W-1:0]  wr_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] pending
);

  logic [NUM_CH-1:0] wr_hit;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // Address decode; selects at or above NUM_CH match no channel.
    assign wr_hit[i] = wr_en && (32'(wr_ch) == 32'(i));

    clk_div_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync_clr (sync_clr),
      .wr       (wr_hit[i]),
      .wr_div   (wr_div),
      .clk_out  (clk_out[i]),
      .tick     (tick[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  localparam int unsigned NUM_CH  = 5;
  localparam int unsigned DIV_W   = 8;
  localparam int unsigned DEF_DIV = 2;
  localparam int unsigned CH_W    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              sync_clr;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [DIV_W-1:0]  wr_div;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] pending;

  clk_div_multi #(
    .NUM_CH  (NUM_CH),
    .DIV_W   (DIV_W),
    .DEF_DIV (DEF_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .wr_en    (wr_en),
    .wr_ch    (wr_ch),
    .wr_div   (wr_div),
    .clk_out  (clk_out),
    .tick     (tick),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] c;
    logic [NUM_CH-1:0] t;
    logic [NUM_CH-1:0] p;
  } exp_t;

  exp_t sb[$];
  exp_t mx;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: each channel is a divisor plus a position inside the
  // current period; outputs are derived from that position.
  int m_div [NUM_CH];
  int m_pos [NUM_CH];
  int m_pdiv[NUM_CH];
  bit m_pend[NUM_CH];
  bit m_clk [NUM_CH];
  bit m_tick[NUM_CH];

  function automatic void set_phase_out(int i);
    m_clk[i]  = (m_pos[i] < (m_div[i] + 1) / 2);
    m_tick[i] = (m_pos[i] == m_div[i] - 1);
  endfunction

  function automatic void model_step(bit r, bit e, bit s, bit w, int ch, int dv);
    for (int i = 0; i < NUM_CH; i++) begin
      bit hit;
      int d;
      hit = w && (ch == i);
      if (!r) begin
        m_div[i] = DEF_DIV; m_pos[i] = DEF_DIV - 1;
        m_pend[i] = 0; m_pdiv[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else if (s) begin
        d = m_pend[i] ? m_pdiv[i] : (hit ? dv : m_div[i]);
        m_div[i] = d; m_pos[i] = (d > 0) ? d - 1 : 0;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else if (m_div[i] == 0) begin
        if (hit && dv != 0) begin
          m_div[i] = dv; m_pos[i] = dv - 1;
        end
        if (e) begin
          m_clk[i] = 0; m_tick[i] = 0;
        end
      end else if (!e) begin
        if (hit) begin
          m_pdiv[i] = dv; m_pend[i] = 1;
        end
      end else if (m_pos[i] == m_div[i] - 1) begin
        // Period boundary: newest divisor takes over for the next period.
        d = hit ? dv : (m_pend[i] ? m_pdiv[i] : m_div[i]);
        m_pend[i] = 0; m_div[i] = d; m_pos[i] = 0;
        if (d == 0) begin
          m_clk[i] = 0; m_tick[i] = 0;
        end else begin
          set_phase_out(i);
        end
      end else begin
        m_pos[i] = m_pos[i] + 1;
        set_phase_out(i);
        if (hit) begin
          m_pdiv[i] = dv; m_pend[i] = 1;
        end
      end
    end
  endfunction

  // One clock: drive inputs, advance the model, queue the expected outputs.
  task automatic cyc(input bit r, input bit e, input bit s, input bit w,
                     input int ch, input int dv);
    exp_t x;
    rst = r; en = e; sync_clr = s; wr_en = w;
    wr_ch = CH_W'(ch); wr_div = DIV_W'(dv);
    model_step(r, e, s, w, ch, dv);
    for (int i = 0; i < NUM_CH; i++) begin
      x.c[i] = m_clk[i];
      x.t[i] = m_tick[i];
      x.p[i] = m_pend[i];
    end
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit e);
    for (int k = 0; k < n; k++) cyc(1, e, 0, 0, 0, 0);
  endtask

  task automatic wr(input int ch, input int dv);
    cyc(1, 1, 0, 1, ch, dv);
  endtask

  // Run idle cycles until channel ch reaches position pos (bounded).
  task automatic run_to(input int ch, input int pos);
    int k;
    k = 0;
    while (m_pos[ch] != pos && k < 300) begin
      idle(1, 1);
      k++;
    end
    if (k >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL run_to ch%0d: position %0d not reached, at %0d", ch, pos, m_pos[ch]);
    end
  endtask

  function automatic void check(string nm, logic [NUM_CH-1:0] got, logic [NUM_CH-1:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, want);
    end
  endfunction

  // Monitor: compare DUT outputs against the oldest expected entry.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mx = sb.pop_front();
      check("clk_out", clk_out, mx.c);
      check("tick",    tick,    mx.t);
      check("pending", pending, mx.p);
    end
  end

  initial begin
    // Reset, then default divide-by-2 on every channel.
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    idle(6, 1);

    // Odd divisor on ch1, applied at its boundary.
    wr(1, 5);
    idle(14, 1);

    // ch0 to D=4, then D=3 written mid-period, then a write on the wrap edge.
    wr(0, 4);
    idle(6, 1);
    run_to(0, 1);
    wr(0, 3);
    idle(8, 1);
    run_to(0, 2);
    wr(0, 4);
    idle(9, 1);

    // Stop ch2, then restart it with D=6.
    wr(2, 0);
    idle(10, 1);
    wr(2, 6);
    idle(14, 1);

    // ch3 at D=1, freeze with a write to ch0 during the freeze.
    wr(3, 1);
    idle(5, 1);
    idle(2, 0);
    cyc(1, 0, 0, 1, 0, 7);
    idle(2, 0);
    idle(16, 1);

    // Phase alignment with D=2,3,4,5 and ignored out-of-range writes.
    wr(0, 2); wr(1, 3); wr(2, 4); wr(3, 5);
    idle(int'($urandom_range(3, 20)), 1);
    cyc(1, 1, 1, 1, 5, 9);
    idle(30, 1);
    wr(6, 1);
    wr(7, 0);
    idle(30, 1);

    // Randomised traffic.
    for (int k = 0; k < 500; k++) begin
      bit r, e, s, w;
      int ch, dv;
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 9) != 0);
      s  = ($urandom_range(0, 59) == 0);
      w  = ($urandom_range(0, 3) == 0);
      ch = int'($urandom_range(0, 7));
      dv = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 255))
                                        : int'($urandom_range(0, 9));
      cyc(r, e, s, w, ch, dv);
    end
    idle(20, 1);

    @(negedge clk);
    #1;
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, 0 required", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
